// File: rtl/tx_arbiter_pkg.sv
// Shared frame constants, tx FIFO counter width and arbiter state encoding.
package tx_arbiter_pkg;

  localparam int UART_FIFO_COUNTER_W = 5;

  localparam logic [7:0] FRM_SYNC0    = 8'hEB;
  localparam logic [7:0] FRM_SYNC1    = 8'h90;
  localparam logic [7:0] FRM_TAIL0    = 8'h09;
  localparam logic [7:0] FRM_TAIL1    = 8'hD7;
  localparam logic [7:0] FRM_BOARD_ID = 8'hAB;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_RELAY    = 3'b010,
    ST_ACK_SEND = 3'b100
  } tx_state_e;

  // Bytes 2..5 of the ack frame sum to zero mod 256.
  function automatic logic [7:0] frame_chk(input logic [7:0] board,
                                           input logic [7:0] cmd,
                                           input logic [7:0] code);
    return 8'h00 - board - cmd - code;
  endfunction

endpackage

// File: rtl/tx_arbiter_ack_frame_builder.sv
// Combinational ack frame byte lookup: EB 90 CHK BOARD cmd code 09 D7.
module ack_frame_builder
  import tx_arbiter_pkg::*;
#(
  parameter logic [7:0] BOARD_ID = FRM_BOARD_ID
) (
  input  logic [2:0] idx_i,
  input  logic [7:0] cmd_i,
  input  logic [7:0] code_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      3'd0: byte_o = FRM_SYNC0;
      3'd1: byte_o = FRM_SYNC1;
      3'd2: byte_o = frame_chk(BOARD_ID, cmd_i, code_i);
      3'd3: byte_o = BOARD_ID;
      3'd4: byte_o = cmd_i;
      3'd5: byte_o = code_i;
      3'd6: byte_o = FRM_TAIL0;
      3'd7: byte_o = FRM_TAIL1;
    endcase
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates the tx FIFO between relayed rx bytes and 8-byte ack frames,
// pacing pushes and holding one pending ack request.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int         GAP_CYCLES    = 16,
  parameter int         TX_FIFO_DEPTH = 16,
  parameter int         PUSH_SPACING  = 3,
  parameter logic [7:0] BOARD_ID      = FRM_BOARD_ID
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           relay_valid,
  input  logic [7:0]                     relay_data,
  output logic                           relay_ack,
  input  logic                           ack_req,
  input  logic [7:0]                     ack_cmd,
  input  logic [7:0]                     ack_code,
  input  logic [UART_FIFO_COUNTER_W-1:0] tf_count,
  output logic                           tf_push,
  output logic [7:0]                     tdr,
  output logic                           ack_busy,
  output logic [7:0]                     drop_cnt
);

  localparam int PW = (PUSH_SPACING > 2) ? $clog2(PUSH_SPACING) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [UART_FIFO_COUNTER_W-1:0] DEPTH_C = UART_FIFO_COUNTER_W'(TX_FIFO_DEPTH);

  tx_state_e   state_q;
  logic [PW-1:0] pace_q;
  logic [GW-1:0] gap_q;
  logic [2:0]  idx_q;
  logic        pend_vld_q;
  logic [7:0]  pend_cmd_q, pend_code_q;
  logic [7:0]  act_cmd_q, act_code_q;
  logic [7:0]  drop_q;

  logic        can_push, relay_push, ack_push, pend_take_d;
  logic [7:0]  frame_byte;

  ack_frame_builder #(.BOARD_ID(BOARD_ID)) u_frame (
    .idx_i  (idx_q),
    .cmd_i  (act_cmd_q),
    .code_i (act_code_q),
    .byte_o (frame_byte)
  );

  // Outputs are qualified by rst so nothing is pushed or popped in a reset cycle.
  assign can_push    = !rst && (tf_count < DEPTH_C) && (pace_q == '0);
  assign relay_push  = can_push && (state_q == ST_RELAY) && relay_valid;
  assign ack_push    = can_push && (state_q == ST_ACK_SEND);
  assign pend_take_d = (state_q == ST_IDLE) && pend_vld_q;

  assign tf_push   = relay_push | ack_push;
  assign relay_ack = relay_push;
  assign tdr       = relay_push ? relay_data : (ack_push ? frame_byte : 8'h00);
  assign ack_busy  = pend_vld_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pace_q      <= '0;
      gap_q       <= '0;
      idx_q       <= 3'd0;
      pend_vld_q  <= 1'b0;
      pend_cmd_q  <= 8'h00;
      pend_code_q <= 8'h00;
      act_cmd_q   <= 8'h00;
      act_code_q  <= 8'h00;
      drop_q      <= 8'h00;
    end else begin
      if (tf_push) begin
        pace_q <= PW'(PUSH_SPACING - 1);
      end else if (pace_q != '0) begin
        pace_q <= pace_q - PW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (pend_vld_q) begin
            act_cmd_q  <= pend_cmd_q;
            act_code_q <= pend_code_q;
            idx_q      <= 3'd0;
            state_q    <= ST_ACK_SEND;
          end else if (relay_valid) begin
            gap_q   <= '0;
            state_q <= ST_RELAY;
          end
        end
        ST_RELAY: begin
          // Idle cycles count even while the FIFO is full.
          if (relay_valid) begin
            gap_q <= '0;
          end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        ST_ACK_SEND: begin
          if (ack_push) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A request arriving as the slot is emptied refills it rather than dropping.
      if (ack_req) begin
        if (!pend_vld_q || pend_take_d) begin
          pend_vld_q  <= 1'b1;
          pend_cmd_q  <= ack_cmd;
          pend_code_q <= ack_code;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (pend_take_d) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: cycle-level reference model plus directed literal frames.
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int         GAP   = 16;
  localparam int         DEPTH = 16;
  localparam int         SP    = 3;
  localparam logic [7:0] BID   = 8'hAB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic relay_valid = 1'b0;
  logic [7:0] relay_data = 8'h00;
  logic relay_ack;
  logic ack_req = 1'b0;
  logic [7:0] ack_cmd = 8'h00;
  logic [7:0] ack_code = 8'h00;
  logic [UART_FIFO_COUNTER_W-1:0] tf_count = '0;
  logic tf_push;
  logic [7:0] tdr;
  logic ack_busy;
  logic [7:0] drop_cnt;

  tx_arbiter dut (
    .clk(clk), .rst(rst), .relay_valid(relay_valid), .relay_data(relay_data),
    .relay_ack(relay_ack), .ack_req(ack_req), .ack_cmd(ack_cmd), .ack_code(ack_code),
    .tf_count(tf_count), .tf_push(tf_push), .tdr(tdr), .ack_busy(ack_busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Relay source and push log
  logic [7:0] src[$];
  bit   src_en = 0;
  int   pop_cnt = 0, pops_done = 0;
  logic [7:0] got[$];
  int   pcyc[$];
  int   ncyc = 0, req_cyc = 0;

  // Reference model state
  bit   mdl_live = 0;
  int   m_mode = 0;            // 0 idle, 1 relaying, 2 sending a frame
  int   m_pace = 0, m_gap = 0, m_drop = 0;
  bit   m_pend = 0;
  logic [7:0] m_pcmd = 0, m_pcode = 0;
  logic [7:0] m_frame[$];
  bit   e_rp, e_ap, e_take;
  logic [7:0] e_tdr;

  task automatic build_frame(input logic [7:0] cmd, input logic [7:0] code);
    int s;
    s = (1024 - int'(BID) - int'(cmd) - int'(code)) % 256;
    m_frame.delete();
    m_frame.push_back(8'hEB); m_frame.push_back(8'h90);
    m_frame.push_back(8'(s));  m_frame.push_back(BID);
    m_frame.push_back(cmd);    m_frame.push_back(code);
    m_frame.push_back(8'h09);  m_frame.push_back(8'hD7);
  endtask

  always @(negedge clk) begin
    ncyc++;
    e_rp = !rst && m_mode == 1 && relay_valid && int'(tf_count) < DEPTH && m_pace == 0;
    e_ap = !rst && m_mode == 2 && int'(tf_count) < DEPTH && m_pace == 0;
    e_tdr = e_rp ? relay_data : (e_ap ? m_frame[0] : 8'h00);
    if (mdl_live) begin
      chk("tf_push", 32'(tf_push), 32'(e_rp | e_ap));
      chk("relay_ack", 32'(relay_ack), 32'(e_rp));
      chk("tdr", 32'(tdr), 32'(e_tdr));
      chk("ack_busy", 32'(ack_busy), 32'(m_pend));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
    if (relay_ack === 1'b1) pop_cnt++;
    if (tf_push === 1'b1) begin
      got.push_back(tdr);
      pcyc.push_back(ncyc);
    end
    if (ack_req && !rst) req_cyc = ncyc;

    if (rst) begin
      mdl_live = 1; m_mode = 0; m_pace = 0; m_gap = 0; m_drop = 0; m_pend = 0;
      m_frame.delete();
    end else begin
      e_take = (m_mode == 0) && m_pend;
      if (e_rp || e_ap) m_pace = SP - 1;
      else if (m_pace > 0) m_pace--;
      if (m_mode == 0) begin
        if (m_pend) begin build_frame(m_pcmd, m_pcode); m_mode = 2; end
        else if (relay_valid) begin m_mode = 1; m_gap = 0; end
      end else if (m_mode == 1) begin
        if (relay_valid) m_gap = 0;
        else begin
          m_gap++;
          if (m_gap == GAP) begin m_mode = 0; m_gap = 0; end
        end
      end else if (e_ap) begin
        void'(m_frame.pop_front());
        if (m_frame.size() == 0) m_mode = 0;
      end
      if (ack_req) begin
        if (!m_pend || e_take) begin m_pend = 1; m_pcmd = ack_cmd; m_pcode = ack_code; end
        else if (m_drop < 255) m_drop++;
      end else if (e_take) m_pend = 0;
    end
  end

  task automatic refresh();
    while (pops_done < pop_cnt) begin
      if (src.size() > 0) void'(src.pop_front());
      pops_done++;
    end
    relay_valid = src_en && src.size() > 0;
    relay_data  = relay_valid ? src[0] : 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ack_req = 0;
    refresh();
  endtask

  task automatic do_reset();
    rst = 1; src.delete(); pops_done = pop_cnt; src_en = 0; tf_count = '0;
    refresh();
    step(); step();
    rst = 0; got.delete(); pcyc.delete();
  endtask

  task automatic send_req(input logic [7:0] cmd, input logic [7:0] code);
    ack_cmd = cmd; ack_code = code; ack_req = 1;
    step();
  endtask

  task automatic wait_pushes(input int n, input int budget, input string nm);
    int k = 0;
    while (got.size() < n && k < budget) begin step(); k++; end
    chk(nm, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic chk_frame(input string nm, input int base, input logic [7:0] cmd,
                           input logic [7:0] code, input logic [7:0] sum_byte);
    logic [7:0] ex[8];
    ex[0] = 8'hEB; ex[1] = 8'h90; ex[2] = sum_byte; ex[3] = 8'hAB;
    ex[4] = cmd;   ex[5] = code;  ex[6] = 8'h09;    ex[7] = 8'hD7;
    for (int i = 0; i < 8; i++) chk($sformatf("%s_b%0d", nm, i), 32'(got[base+i]), 32'(ex[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    refresh();
    step(); step();
    rst = 0;
    chk("rst_tf_push", 32'(tf_push), 32'd0);
    chk("rst_relay_ack", 32'(relay_ack), 32'd0);
    chk("rst_tdr", 32'(tdr), 32'd0);
    chk("rst_ack_busy", 32'(ack_busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Single ack from idle
    do_reset();
    send_req(8'h0A, 8'h00);
    wait_pushes(8, 100, "t1_done");
    chk_frame("t1", 0, 8'h0A, 8'h00, 8'h4B);
    chk("t1_latency", 32'(pcyc[0] - req_cyc), 32'd2);
    for (int i = 1; i < 8; i++) chk("t1_spacing", 32'(pcyc[i] - pcyc[i-1]), 32'd3);

    // Relay burst with an ack requested mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back(8'(8'h11 + i));
    src_en = 1; refresh();
    wait_pushes(2, 50, "t2_start");
    send_req(8'h77, 8'h01);
    wait_pushes(13, 300, "t2_done");
    for (int i = 0; i < 5; i++) chk("t2_relay", 32'(got[i]), 32'(8'h11 + i));
    chk("t2_gap", 32'(pcyc[5] - pcyc[4]), 32'd18);
    chk_frame("t2", 5, 8'h77, 8'h01, 8'hDD);

    // Three requests during one frame
    do_reset();
    send_req(8'h10, 8'h00);
    wait_pushes(1, 50, "t3_start");
    send_req(8'h20, 8'h01);
    step();
    send_req(8'h30, 8'h02);
    step();
    send_req(8'h40, 8'h00);
    wait_pushes(16, 300, "t3_done");
    repeat (40) step();
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    chk("t3_count", 32'(got.size()), 32'd16);
    chk_frame("t3a", 0, 8'h10, 8'h00, 8'h45);
    chk_frame("t3b", 8, 8'h20, 8'h01, 8'h34);

    // FIFO full stall at byte 3
    do_reset();
    send_req(8'h5A, 8'h01);
    wait_pushes(3, 100, "t4_start");
    tf_count = 5'd16;
    repeat (20) step();
    chk("t4_stalled", 32'(got.size()), 32'd3);
    tf_count = 5'd15;
    wait_pushes(8, 100, "t4_done");
    repeat (10) step();
    chk("t4_count", 32'(got.size()), 32'd8);
    chk_frame("t4", 0, 8'h5A, 8'h01, 8'hFA);

    // Reset mid-frame then a clean frame
    do_reset();
    send_req(8'h33, 8'h02);
    wait_pushes(4, 100, "t5_start");
    rst = 1;
    step();
    rst = 0;
    chk("t5_tf_push", 32'(tf_push), 32'd0);
    chk("t5_tdr", 32'(tdr), 32'd0);
    chk("t5_busy", 32'(ack_busy), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd0);
    got.delete(); pcyc.delete();
    send_req(8'h33, 8'h02);
    wait_pushes(8, 100, "t5_done");
    repeat (10) step();
    chk("t5_count", 32'(got.size()), 32'd8);
    chk_frame("t5", 0, 8'h33, 8'h02, 8'h20);

    // Pending ack and relay_valid together in idle
    do_reset();
    src.push_back(8'h21); src.push_back(8'h22); src.push_back(8'h23);
    send_req(8'h01, 8'h00);
    src_en = 1; refresh();
    wait_pushes(11, 200, "t6_done");
    chk_frame("t6", 0, 8'h01, 8'h00, 8'h54);
    for (int i = 0; i < 3; i++) chk("t6_relay", 32'(got[8+i]), 32'(8'h21 + i));

    // Drop counter saturation with the FIFO held full
    do_reset();
    tf_count = 5'd16;
    for (int i = 0; i < 300; i++) begin
      ack_cmd = 8'($urandom); ack_code = 8'($urandom_range(0, 2)); ack_req = 1;
      step();
    end
    chk("t7_drop_sat", 32'(drop_cnt), 32'd255);
    chk("t7_busy", 32'(ack_busy), 32'd1);
    tf_count = '0;
    wait_pushes(16, 200, "t7_done");

    // Randomised traffic
    do_reset();
    src_en = 1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      tf_count = ($urandom_range(0, 9) == 0) ? 5'd16 : 5'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) begin
        ack_req = 1; ack_cmd = 8'($urandom); ack_code = 8'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 39) == 0) begin
        int n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) src.push_back(8'($urandom));
        refresh();
      end
      step();
    end
    rst = 0; tf_count = '0;
    repeat (300) step();
    chk("rand_drained", 32'(m_mode), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
